// File: rtl/led_blink_pkg.sv
// Shared definitions for the multi-channel LED pattern generator.
// Optional PWM dimming is enabled with the LED_PWM_EN macro.
package led_blink_pkg;
  localparam int MODE_W = 2;
  localparam int DUTY_W = 8;

  localparam logic [MODE_W-1:0] MODE_OFF     = 2'b00;
  localparam logic [MODE_W-1:0] MODE_ON      = 2'b01;
  localparam logic [MODE_W-1:0] MODE_BLINK   = 2'b10;
  localparam logic [MODE_W-1:0] MODE_ONESHOT = 2'b11;

  // Config port handshake: BUSY is the one-cycle gap after each accept.
  typedef enum logic {HS_BUSY, HS_READY} hs_e;
endpackage

// File: rtl/led_blink_if.sv
// Config write port: valid/ready handshake plus channel, mode, half-period (and duty with LED_PWM_EN).
interface led_blink_if import led_blink_pkg::*; #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 16
);
  localparam int CH_W = $clog2(NUM_CH) + 1;

  logic              valid;
  logic              ready;
  logic [CH_W-1:0]   ch;
  logic [MODE_W-1:0] mode;
  logic [CNT_W-1:0]  half;
  logic              err;
`ifdef LED_PWM_EN
  logic [DUTY_W-1:0] duty;
`endif

  modport master (
    output valid, ch, mode, half,
`ifdef LED_PWM_EN
    output duty,
`endif
    input  ready, err
  );

  modport slave (
    input  valid, ch, mode, half,
`ifdef LED_PWM_EN
    input  duty,
`endif
    output ready, err
  );
endinterface

// File: rtl/led_blink_chan.sv
// One LED channel: mode/half-period/tick counter/output state registers (+duty with LED_PWM_EN).
module led_blink_chan import led_blink_pkg::*; #(
  parameter int                CNT_W    = 16,
  parameter int                DEF_HALF = 500,
  parameter logic [MODE_W-1:0] DEF_MODE = MODE_BLINK
)(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              tick,
  input  logic              wr,
  input  logic [MODE_W-1:0] wr_mode,
  input  logic [CNT_W-1:0]  wr_half,
`ifdef LED_PWM_EN
  input  logic [DUTY_W-1:0] wr_duty,
  output logic [DUTY_W-1:0] duty,
`endif
  output logic              state
);
  logic [MODE_W-1:0] mode;
  logic [CNT_W-1:0]  half, cnt, half_eff;
  logic              last;

  // A programmed half-period of 0 behaves as 1 tick.
  assign half_eff = (half == '0) ? CNT_W'(1) : half;
  assign last     = (cnt == half_eff - CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode  <= DEF_MODE;
      half  <= CNT_W'(DEF_HALF);
      cnt   <= '0;
      state <= 1'b0;
    end else if (wr) begin
      // A write on a tick edge restarts the pattern; that tick is dropped.
      mode  <= wr_mode;
      half  <= wr_half;
      cnt   <= '0;
      state <= (wr_mode != MODE_OFF);
    end else if (tick) begin
      case (mode)
        MODE_BLINK: begin
          if (last) begin
            state <= ~state;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        MODE_ONESHOT: begin
          if (last) begin
            state <= 1'b0;
            cnt   <= '0;
            mode  <= MODE_OFF;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        MODE_ON: begin
          state <= 1'b1;
          cnt   <= '0;
        end
        default: begin
          state <= 1'b0;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef LED_PWM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  duty <= '1;
    else if (wr) duty <= wr_duty;
  end
`endif
endmodule

// File: rtl/led_blink_multi.sv
// NUM_CH-channel LED pattern generator: shared prescaler, config handshake, channel array.
// LED_PWM_EN adds a per-channel 8-bit duty and a shared clock-rate PWM counter.
module led_blink_multi import led_blink_pkg::*; #(
  parameter int                NUM_CH   = 4,
  parameter int                CNT_W    = 16,
  parameter int                PRESCALE = 25,
  parameter int                DEF_HALF = 500,
  parameter logic [MODE_W-1:0] DEF_MODE = MODE_BLINK
)(
  input  logic              i_clock,
  input  logic              i_rst_n,
  input  logic              i_enable,
  led_blink_if.slave        cfg,
  output logic [NUM_CH-1:0] o_led_drive
);
  localparam int CH_W = $clog2(NUM_CH) + 1;
  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PS_W-1:0]   ps;
  logic              tick;
  hs_e               hs_q, hs_d;
  logic              accept;
  logic [NUM_CH-1:0] wr, state;

  // Free-running prescaler; config writes never disturb it.
  assign tick = (ps == PS_W'(PRESCALE - 1));

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n)  ps <= '0;
    else if (tick) ps <= '0;
    else           ps <= ps + PS_W'(1);
  end

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) hs_q <= HS_BUSY;
    else          hs_q <= hs_d;
  end

  always_comb begin
    hs_d = hs_q;
    case (hs_q)
      HS_READY: if (cfg.valid) hs_d = HS_BUSY;
      default:  hs_d = HS_READY;
    endcase
  end

  assign cfg.ready = (hs_q == HS_READY);
  assign accept    = cfg.valid && cfg.ready;

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) cfg.err <= 1'b0;
    else          cfg.err <= accept && (cfg.ch >= CH_W'(NUM_CH));
  end

`ifdef LED_PWM_EN
  logic [DUTY_W-1:0]             pwm_cnt;
  logic [NUM_CH-1:0][DUTY_W-1:0] duty;

  always_ff @(posedge i_clock or negedge i_rst_n) begin
    if (!i_rst_n) pwm_cnt <= '0;
    else          pwm_cnt <= pwm_cnt + DUTY_W'(1);
  end
`endif

  for (genvar n = 0; n < NUM_CH; n++) begin : g_ch
    assign wr[n] = accept && (cfg.ch == CH_W'(n));

    led_blink_chan #(
      .CNT_W    (CNT_W),
      .DEF_HALF (DEF_HALF),
      .DEF_MODE (DEF_MODE)
    ) u_ch (
      .clk     (i_clock),
      .rst_n   (i_rst_n),
      .tick    (tick),
      .wr      (wr[n]),
      .wr_mode (cfg.mode),
      .wr_half (cfg.half),
`ifdef LED_PWM_EN
      .wr_duty (cfg.duty),
      .duty    (duty[n]),
`endif
      .state   (state[n])
    );

`ifdef LED_PWM_EN
    assign o_led_drive[n] = state[n] & i_enable & (pwm_cnt < duty[n]);
`else
    assign o_led_drive[n] = state[n] & i_enable;
`endif
  end
endmodule

// File: tb/tb_led_blink_multi.sv
// Directed bench for led_blink_multi (NUM_CH=4, CNT_W=16, PRESCALE=5).
module tb_led_blink_multi;
  import led_blink_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [3:0] led;
  int         n_chk  = 0;
  int         n_pass = 0;
  int         cyc    = 0;

  led_blink_if #(.NUM_CH(4), .CNT_W(16)) cfg();

  led_blink_multi #(
    .NUM_CH(4), .CNT_W(16), .PRESCALE(5), .DEF_HALF(500), .DEF_MODE(MODE_BLINK)
  ) dut (
    .i_clock     (clk),
    .i_rst_n     (rst_n),
    .i_enable    (enable),
    .cfg         (cfg),
    .o_led_drive (led)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    else             n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic cfg_write(input int ch, input logic [1:0] mode, input int half);
    int w = 0;
    while (cfg.ready !== 1'b1 && w < 10) begin
      step();
      w++;
    end
    chk("wr_ready", cfg.ready, 1);
    cfg.valid = 1'b1;
    cfg.ch    = 3'(ch);
    cfg.mode  = mode;
    cfg.half  = 16'(half);
    step();
    cfg.valid = 1'b0;
    chk("ready_gap", cfg.ready, 0);
  endtask

  task automatic find_toggle(input int b, output int t);
    logic p;
    logic found;
    p     = led[b];
    found = 1'b0;
    t     = -1;
    for (int k = 0; k < 200 && !found; k++) begin
      step();
      if (led[b] !== p) begin
        found = 1'b1;
        t     = cyc;
      end
    end
    chk("toggle_seen", found, 1);
  endtask

  initial begin
    int t0, t1, t2, ta, tb, hi, acc, idx;
    logic va;
    logic [1:0] bb_mode [4];

    rst_n     = 1'b0;
    enable    = 1'b1;
    cfg.valid = 1'b0;
    cfg.ch    = '0;
    cfg.mode  = '0;
    cfg.half  = '0;

    // Reset held 3 clocks
    repeat (3) step();
    chk("rst_led", led, 4'h0);
    chk("rst_ready", cfg.ready, 0);
    chk("rst_err", cfg.err, 0);
    rst_n = 1'b1;
    cyc   = 0;
    step();
    chk("ready_after_rst", cfg.ready, 1);
    repeat (2498) step();
    chk("pre_first_toggle", led, 4'h0);
    step();
    chk("first_toggle_2500", led, 4'hF);

    // ch1 BLINK half=3: 15 clocks per phase
    cfg_write(1, MODE_BLINK, 3);
    chk("ch1_on_after_wr", led[1], 1);
    step();
    chk("ready_back", cfg.ready, 1);
    find_toggle(1, t0);
    find_toggle(1, t1);
    find_toggle(1, t2);
    chk("blink1_lo", t1 - t0, 15);
    chk("blink1_hi", t2 - t1, 15);

    // ch2 ONESHOT half=4: high 16..20 clocks then OFF
    cfg_write(2, MODE_ONESHOT, 4);
    hi = 0;
    for (int k = 0; k < 40 && led[2]; k++) begin
      hi++;
      step();
    end
    chk("oneshot_len_16_20", (hi >= 16 && hi <= 20), 1);
    repeat (30) step();
    chk("oneshot_stays_off", led[2], 0);
    chk("oneshot_mode_off", dut.g_ch[2].u_ch.mode, MODE_OFF);

    // Quiet the array, then an out-of-range write
    cfg_write(0, MODE_OFF, 0);
    cfg_write(1, MODE_ON, 0);
    cfg_write(3, MODE_ON, 0);
    chk("static_leds", led, 4'b1010);
    cfg_write(5, MODE_ON, 0);
    chk("err_pulse", cfg.err, 1);
    chk("err_led_same", led, 4'b1010);
    step();
    chk("err_cleared", cfg.err, 0);
    chk("err_led_still", led, 4'b1010);

    // ch3 BLINK half=0 -> toggles every tick
    cfg_write(3, MODE_BLINK, 0);
    chk("ch3_on_after_wr", led[3], 1);
    find_toggle(3, t0);
    find_toggle(3, t1);
    find_toggle(3, t2);
    chk("half0_period_a", t1 - t0, 5);
    chk("half0_period_b", t2 - t1, 5);
    ta = t2;
    va = led[3];
    enable = 1'b0;
    #1;
    chk("enable_low_now", led, 4'h0);
    repeat (7) step();
    chk("enable_low_7", led, 4'h0);
    enable = 1'b1;
    #1;
    chk("phase_resume", led[3], va ^ (((cyc - ta) / 5) % 2 == 1));
    find_toggle(3, tb);
    chk("phase_continuous", (tb - ta) % 5, 0);

    // Back-to-back writes held valid for 8 clocks
    bb_mode[0] = MODE_ON; bb_mode[1] = MODE_OFF; bb_mode[2] = MODE_ON; bb_mode[3] = MODE_ON;
    while (cfg.ready !== 1'b1) step();
    acc = 0;
    idx = 0;
    for (int k = 0; k < 8; k++) begin
      logic r;
      cfg.valid = (idx < 4);
      cfg.ch    = 3'(idx);
      cfg.mode  = bb_mode[idx % 4];
      cfg.half  = 16'd1;
      r = cfg.ready;
      step();
      if (cfg.valid && r) begin
        acc++;
        idx++;
      end
    end
    cfg.valid = 1'b0;
    chk("b2b_accepts", acc, 4);
    chk("b2b_leds", led, 4'b1101);

    // Asynchronous reset mid-pattern
    rst_n = 1'b0;
    #1;
    chk("async_rst_led", led, 4'h0);
    chk("async_rst_ready", cfg.ready, 0);
    chk("async_rst_mode", dut.g_ch[1].u_ch.mode, MODE_BLINK);
    repeat (2) step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("post_rst_led", led, 4'h0);
    chk("post_rst_ready", cfg.ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
